// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mod_counter
// Description : Cascadable two-digit BCD up/down counter, modulus MODULO
//               (2..100), with wrap/saturate, sync clear and terminal count.
//               Optional parallel load enabled by macro BCDCNT_LOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter #(
    parameter int MODULO = 60
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       IN_CARRY,
    input  logic       DEC,
    input  logic       SAT,
    input  logic       CLR,
`ifdef BCDCNT_LOAD_EN
    input  logic       LOAD,
    input  logic [3:0] LD_TENS,
    input  logic [3:0] LD_ONES,
`endif
    output logic [3:0] CNT_ONES,
    output logic [3:0] CNT_TENS,
    output logic       OUT_CARRY,
    output logic       TC
);

    localparam logic [3:0] TOP_TENS = 4'((MODULO - 1) / 10);
    localparam logic [3:0] TOP_ONES = 4'((MODULO - 1) % 10);

    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic [3:0] w_ones_nxt;
    logic [3:0] w_tens_nxt;
    logic       w_at_top;
    logic       w_at_zero;
    logic       w_step;

    assign w_at_top  = (r_tens == TOP_TENS) && (r_ones == TOP_ONES);
    assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_step    = ENABLE & IN_CARRY;

    // Carry is derived only from present state, so clearing a lower stage
    // can never leak a stale carry into the stage above.
    assign TC        = DEC ? w_at_zero : w_at_top;
    assign OUT_CARRY = TC & IN_CARRY & ~SAT;

`ifdef BCDCNT_LOAD_EN
    logic [7:0] w_ld_value;
    logic       w_ld_ok;

    assign w_ld_value = 8'(LD_TENS) * 8'd10 + 8'(LD_ONES);
    assign w_ld_ok    = (LD_ONES <= 4'd9) && (w_ld_value < 8'(MODULO));
`endif

    always_comb begin
        w_ones_nxt = r_ones;
        w_tens_nxt = r_tens;
        if (CLR) begin
            w_ones_nxt = 4'd0;
            w_tens_nxt = 4'd0;
        end
`ifdef BCDCNT_LOAD_EN
        else if (LOAD) begin
            if (w_ld_ok) begin
                w_ones_nxt = LD_ONES;
                w_tens_nxt = LD_TENS;
            end
        end
`endif
        else if (w_step) begin
            if (!DEC) begin
                if (w_at_top) begin
                    if (!SAT) begin
                        w_ones_nxt = 4'd0;
                        w_tens_nxt = 4'd0;
                    end
                end else if (r_ones == 4'd9) begin
                    w_ones_nxt = 4'd0;
                    w_tens_nxt = r_tens + 4'd1;
                end else begin
                    w_ones_nxt = r_ones + 4'd1;
                end
            end else begin
                if (w_at_zero) begin
                    if (!SAT) begin
                        w_ones_nxt = TOP_ONES;
                        w_tens_nxt = TOP_TENS;
                    end
                end else if (r_ones == 4'd0) begin
                    w_ones_nxt = 4'd9;
                    w_tens_nxt = r_tens - 4'd1;
                end else begin
                    w_ones_nxt = r_ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
        end else begin
            r_ones <= w_ones_nxt;
            r_tens <= w_tens_nxt;
        end
    end

    assign CNT_ONES = r_ones;
    assign CNT_TENS = r_tens;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_mod_counter
// Description : Four counters (mod 60, 24, 100, 7) against an integer model;
//               mod-60 can drive mod-24 as a two-stage chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_mod_counter;

    localparam int MODS [4] = '{60, 24, 100, 7};

    logic       CLK = 1'b0;
    logic       RESET;
    logic       en  [4];
    logic       ic  [4];
    logic       dec [4];
    logic       sat [4];
    logic       clr [4];
    logic [3:0] ones[4];
    logic [3:0] tens[4];
    logic       oc  [4];
    logic       tc  [4];
    logic       chain;
    logic       w_ic24;
`ifdef BCDCNT_LOAD_EN
    logic       ld  [4];
    logic [3:0] ldt [4];
    logic [3:0] ldo [4];
`endif

    int mv[4];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    assign w_ic24 = chain ? oc[0] : ic[1];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bcd_mod_counter #(.MODULO(MODS[g])) u_dut (
            .CLK      (CLK),
            .RESET    (RESET),
            .ENABLE   (en[g]),
            .IN_CARRY ((g == 1) ? w_ic24 : ic[g]),
            .DEC      (dec[g]),
            .SAT      (sat[g]),
            .CLR      (clr[g]),
`ifdef BCDCNT_LOAD_EN
            .LOAD     (ld[g]),
            .LD_TENS  (ldt[g]),
            .LD_ONES  (ldo[g]),
`endif
            .CNT_ONES (ones[g]),
            .CNT_TENS (tens[g]),
            .OUT_CARRY(oc[g]),
            .TC       (tc[g])
        );
    end

    // Reference model: plain integer counting modulo MODS[k]
    function automatic logic exp_tc(int k);
        return dec[k] ? (mv[k] == 0) : (mv[k] == MODS[k] - 1);
    endfunction

    function automatic logic exp_ci(int k);
        if (k == 1 && chain) return exp_tc(0) && ic[0] && !sat[0];
        return ic[k];
    endfunction

    function automatic logic exp_oc(int k);
        return exp_tc(k) && exp_ci(k) && !sat[k];
    endfunction

    function automatic int model_next(int k);
        int v = mv[k];
        int m = MODS[k];
        if (clr[k]) return 0;
`ifdef BCDCNT_LOAD_EN
        if (ld[k]) begin
            if (int'(ldo[k]) <= 9 && int'(ldt[k]) * 10 + int'(ldo[k]) < m)
                return int'(ldt[k]) * 10 + int'(ldo[k]);
            return v;
        end
`endif
        if (en[k] && exp_ci(k)) begin
            if (!dec[k]) return (v == m - 1) ? (sat[k] ? v : 0) : v + 1;
            return (v == 0) ? (sat[k] ? v : m - 1) : v - 1;
        end
        return v;
    endfunction

    task automatic tick();
        int nv[4];
        for (int k = 0; k < 4; k++) nv[k] = model_next(k);
        @(posedge CLK);
        for (int k = 0; k < 4; k++) mv[k] = nv[k];
        #1;
    endtask

    task automatic idle_inputs();
        chain = 1'b0;
        for (int k = 0; k < 4; k++) begin
            en[k] = 0; ic[k] = 1; dec[k] = 0; sat[k] = 0; clr[k] = 0;
`ifdef BCDCNT_LOAD_EN
            ld[k] = 0; ldt[k] = 0; ldo[k] = 0;
`endif
        end
    endtask

    // Short asynchronous pulse placed between clock edges
    task automatic pulse_reset();
        RESET = 1'b1;
        #1;
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) mv[k] = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (ones[k] !== 4'd0 || tens[k] !== 4'd0 || tc[k] !== 1'b0 || oc[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst %0d: got %0d%0d tc=%b oc=%b, exp 00 tc=0 oc=0",
                         k, tens[k], ones[k], tc[k], oc[k]);
            end
        end
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) mv[k] = 0;
    endtask

    task automatic test_up_wrap60();
        idle_inputs();
        en[0] = 1;
        for (int i = 1; i <= 60; i++) begin
            n_tests++;
            if (tc[0] !== ((i - 1) == 59) || oc[0] !== ((i - 1) == 59)) begin
                n_fail++;
                $display("FAIL up60 flags at %0d: tc=%b oc=%b, exp %b", i - 1, tc[0], oc[0], (i - 1) == 59);
            end
            tick();
            n_tests++;
            if (tens[0] !== 4'((i % 60) / 10) || ones[0] !== 4'(i % 10)) begin
                n_fail++;
                $display("FAIL up60 step %0d: got %0d%0d exp %0d", i, tens[0], ones[0], i % 60);
            end
        end
    endtask

    task automatic test_down24();
        int exp_v [3] = '{23, 13, 12};
        int steps [3] = '{1, 10, 1};
        idle_inputs();
        en[1] = 1; dec[1] = 1;
        for (int j = 0; j < 3; j++) begin
            repeat (steps[j]) tick();
            n_tests++;
            if (tens[1] !== 4'(exp_v[j] / 10) || ones[1] !== 4'(exp_v[j] % 10)) begin
                n_fail++;
                $display("FAIL down24 phase %0d: got %0d%0d exp %0d", j, tens[1], ones[1], exp_v[j]);
            end
        end
    endtask

    task automatic test_sat100();
        idle_inputs();
        en[2] = 1; dec[2] = 1;
        tick(); tick();
        n_tests++;
        if (tens[2] !== 4'd9 || ones[2] !== 4'd8) begin
            n_fail++;
            $display("FAIL sat100 setup: got %0d%0d exp 98", tens[2], ones[2]);
        end
        dec[2] = 0; sat[2] = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (tens[2] !== 4'd9 || ones[2] !== 4'd9 || tc[2] !== 1'b1 || oc[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL sat100 hold %0d: got %0d%0d tc=%b oc=%b, exp 99 tc=1 oc=0",
                         i, tens[2], ones[2], tc[2], oc[2]);
            end
        end
        dec[2] = 1;
        tick();
        n_tests++;
        if (tens[2] !== 4'd9 || ones[2] !== 4'd8) begin
            n_fail++;
            $display("FAIL sat100 down: got %0d%0d exp 98", tens[2], ones[2]);
        end
    endtask

    task automatic test_chain();
        idle_inputs();
        pulse_reset();
        en[0] = 1; en[1] = 1; dec[0] = 1; dec[1] = 1;
        tick();
        chain = 1; dec[0] = 0; dec[1] = 0;
        #1;
        n_tests++;
        if (tens[0] !== 4'd5 || ones[0] !== 4'd9 || tens[1] !== 4'd2 || ones[1] !== 4'd3
            || oc[0] !== 1'b1 || oc[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL chain setup: got %0d%0d/%0d%0d oc=%b%b, exp 59/23 oc=11",
                     tens[0], ones[0], tens[1], ones[1], oc[0], oc[1]);
        end
        tick();
        n_tests++;
        if (tens[0] !== 4'd0 || ones[0] !== 4'd0 || tens[1] !== 4'd0 || ones[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL chain wrap: got %0d%0d/%0d%0d exp 00/00", tens[0], ones[0], tens[1], ones[1]);
        end
        ic[0] = 0;
        tick();
        n_tests++;
        if (ones[0] !== 4'd0 || tens[0] !== 4'd0 || ones[1] !== 4'd0 || tens[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL chain no_carry: got %0d%0d/%0d%0d exp 00/00", tens[0], ones[0], tens[1], ones[1]);
        end
        ic[0] = 1;
        tick();
        n_tests++;
        if (ones[0] !== 4'd1 || tens[0] !== 4'd0 || ones[1] !== 4'd0 || tens[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL chain lower_only: got %0d%0d/%0d%0d exp 01/00", tens[0], ones[0], tens[1], ones[1]);
        end
    endtask

    task automatic test_async_reset_clr();
        idle_inputs();
        pulse_reset();
        en[0] = 1;
        repeat (37) tick();
        #2;
        RESET = 1'b1;
        #1;
        n_tests++;
        if (tens[0] !== 4'd0 || ones[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %0d%0d exp 00 (from 37)", tens[0], ones[0]);
        end
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) mv[k] = 0;
        repeat (45) tick();
        n_tests++;
        if (tens[0] !== 4'd4 || ones[0] !== 4'd5) begin
            n_fail++;
            $display("FAIL clr setup: got %0d%0d exp 45", tens[0], ones[0]);
        end
        clr[0] = 1;
        tick();
        n_tests++;
        if (tens[0] !== 4'd0 || ones[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_with_enable: got %0d%0d exp 00", tens[0], ones[0]);
        end
    endtask

    task automatic test_small_mod();
        idle_inputs();
        pulse_reset();
        en[3] = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (tens[3] !== 4'd0 || ones[3] !== 4'(i % 7)) begin
                n_fail++;
                $display("FAIL mod7 up %0d: got %0d%0d exp %0d", i, tens[3], ones[3], i % 7);
            end
        end
        pulse_reset();
        dec[3] = 1;
        tick();
        n_tests++;
        if (tens[3] !== 4'd0 || ones[3] !== 4'd6) begin
            n_fail++;
            $display("FAIL mod7 down_wrap: got %0d%0d exp 06", tens[3], ones[3]);
        end
    endtask

`ifdef BCDCNT_LOAD_EN
    task automatic test_load();
        logic [3:0] lt [4] = '{4'd4, 4'd6, 4'd1, 4'd3};
        logic [3:0] lo [4] = '{4'd2, 4'd0, 4'hA, 4'd3};
        int         ev [4] = '{42, 42, 42, 0};
        idle_inputs();
        pulse_reset();
        for (int j = 0; j < 4; j++) begin
            ld[0] = 1; ldt[0] = lt[j]; ldo[0] = lo[j]; clr[0] = (j == 3);
            tick();
            n_tests++;
            if (tens[0] !== 4'(ev[j] / 10) || ones[0] !== 4'(ev[j] % 10)) begin
                n_fail++;
                $display("FAIL load case %0d: got %0d%0d exp %0d", j, tens[0], ones[0], ev[j]);
            end
        end
    endtask
`endif

    task automatic test_random();
        idle_inputs();
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            chain = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                en[k]  = ($urandom_range(0, 3) != 0);
                ic[k]  = ($urandom_range(0, 4) != 0);
                dec[k] = ($urandom_range(0, 2) == 0);
                sat[k] = ($urandom_range(0, 5) == 0);
                clr[k] = ($urandom_range(0, 15) == 0);
`ifdef BCDCNT_LOAD_EN
                ld[k]  = ($urandom_range(0, 7) == 0);
                ldt[k] = 4'($urandom_range(0, 15));
                ldo[k] = 4'($urandom_range(0, 15));
`endif
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (ones[k] !== 4'(mv[k] % 10) || tens[k] !== 4'(mv[k] / 10)
                    || tc[k] !== exp_tc(k) || oc[k] !== exp_oc(k)) begin
                    n_fail++;
                    $display("FAIL random cyc %0d inst %0d: got %0d%0d tc=%b oc=%b, exp %0d tc=%b oc=%b",
                             c, k, tens[k], ones[k], tc[k], oc[k], mv[k], exp_tc(k), exp_oc(k));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        idle_inputs();
        test_reset();
        test_up_wrap60();
        test_down24();
        test_sat100();
        test_chain();
        test_async_reset_clr();
        test_small_mod();
`ifdef BCDCNT_LOAD_EN
        test_load();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
